// File: rtl/wb_stream_master_pkg.sv
// Shared definitions for the stream-to-Wishbone burst master: FSM state
// encoding and the default bus geometry that sets the per-word address step.
package wb_stream_master_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_WR = 2'd1,
    S_BUS     = 2'd2,
    S_HOLD_RD = 2'd3
  } state_e;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  // Byte lanes per word; also the address increment applied after every ack.
  localparam int unsigned ADDR_INC           = DEFAULT_DATA_WIDTH / 8;

endpackage : wb_stream_master_pkg

// File: rtl/wb_stream_master.sv
// Burst master: takes (addr, count, we) commands and moves words one at a time
// between valid/ready streams and a classic single-cycle Wishbone bus.
module wb_stream_master
  import wb_stream_master_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned SELECT_WIDTH = ADDR_INC,
  parameter int unsigned COUNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [COUNT_WIDTH-1:0]  cmd_count,
  input  logic                    cmd_we,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_we_o,
  output logic [SELECT_WIDTH-1:0] wb_sel_o,
  output logic                    wb_stb_o,
  input  logic                    wb_ack_i,
  output logic                    wb_cyc_o
);

  localparam logic [ADDR_WIDTH-1:0]  ADDR_STEP = ADDR_WIDTH'(SELECT_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] ONE       = COUNT_WIDTH'(1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic [DATA_WIDTH-1:0]   dat_o_q, dat_o_d;
  logic                    we_q, we_d;
  logic                    stb_q, stb_d;
  logic                    busy_q, busy_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    wr_ready_q, wr_ready_d;
  logic                    rd_valid_q, rd_valid_d;

  always_comb begin
    // NOTE: every _d starts as its _q so paths that do not assign it hold state
    // instead of inferring a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    dat_o_d     = dat_o_q;
    we_d        = we_q;
    stb_d       = stb_q;
    busy_d      = busy_q;
    cmd_ready_d = cmd_ready_q;
    wr_ready_d  = wr_ready_q;
    rd_valid_d  = rd_valid_q;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          addr_d  = cmd_addr;
          count_d = cmd_count;
          we_d    = cmd_we;
          // A zero-length command is consumed without ever leaving IDLE.
          if (cmd_count != '0) begin
            cmd_ready_d = 1'b0;
            busy_d      = 1'b1;
            if (cmd_we) begin
              state_d    = S_WAIT_WR;
              wr_ready_d = 1'b1;
            end else begin
              state_d = S_BUS;
              stb_d   = 1'b1;
            end
          end
        end
      end

      S_WAIT_WR: begin
        if (wr_valid && wr_ready_q) begin
          dat_o_d    = wr_data;
          wr_ready_d = 1'b0;
          stb_d      = 1'b1;
          state_d    = S_BUS;
        end
      end

      S_BUS: begin
        if (wb_ack_i) begin
          stb_d   = 1'b0;
          addr_d  = addr_q + ADDR_STEP;
          count_d = count_q - ONE;
          if (!we_q) begin
            rd_data_d  = wb_dat_i;
            rd_valid_d = 1'b1;
            state_d    = S_HOLD_RD;
          end else if (count_q == ONE) begin
            busy_d      = 1'b0;
            cmd_ready_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            wr_ready_d = 1'b1;
            state_d    = S_WAIT_WR;
          end
        end
      end

      S_HOLD_RD: begin
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          if (count_q == '0) begin
            busy_d      = 1'b0;
            cmd_ready_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            stb_d   = 1'b1;
            state_d = S_BUS;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  // NOTE: datapath registers are reset too, so rd_data/wb_dat_o read as zero and
  // no stale burst state survives an abandoned transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      dat_o_q     <= '0;
      we_q        <= 1'b0;
      stb_q       <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      dat_o_q     <= dat_o_d;
      we_q        <= we_d;
      stb_q       <= stb_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
      wr_ready_q  <= wr_ready_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign wr_ready  = wr_ready_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign busy      = busy_q;
  assign wb_adr_o  = addr_q;
  assign wb_dat_o  = dat_o_q;
  assign wb_we_o   = we_q;
  assign wb_sel_o  = {SELECT_WIDTH{1'b1}};
  assign wb_stb_o  = stb_q;
  assign wb_cyc_o  = stb_q;

endmodule : wb_stream_master

// File: tb/tb_wb_stream_master.sv
// Randomised bench for wb_stream_master: a behavioural Wishbone RAM slave with
// programmable wait states, a bus monitor, and a reference memory model.
module tb_wb_stream_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [CW-1:0] cmd_count = '0;
  logic          cmd_we = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic          busy;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_i;
  logic [DW-1:0] wb_dat_o;
  logic          wb_we_o;
  logic [SW-1:0] wb_sel_o;
  logic          wb_stb_o;
  logic          wb_ack_i;
  logic          wb_cyc_o;

  always #5 clk = ~clk;

  wb_stream_master #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_count(cmd_count), .cmd_we(cmd_we),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy),
    .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i), .wb_cyc_o(wb_cyc_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // ---------------- Wishbone RAM slave (registered ack, wait states) -------
  logic [31:0] slv_mem [logic [31:0]];
  int          slv_wait = 0;
  int          slv_cnt;
  logic        ack_q;
  logic [31:0] slv_rdata;

  assign wb_ack_i = ack_q;
  assign wb_dat_i = slv_rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q     <= 1'b0;
      slv_cnt   <= 0;
      slv_rdata <= '0;
    end else if (wb_stb_o && wb_cyc_o && !ack_q) begin
      if (slv_cnt >= slv_wait) begin
        ack_q   <= 1'b1;
        slv_cnt <= 0;
        if (wb_we_o) slv_mem[wb_adr_o] = wb_dat_o;
        else slv_rdata <= slv_mem.exists(wb_adr_o) ? slv_mem[wb_adr_o] : init_word(wb_adr_o);
      end else begin
        slv_cnt <= slv_cnt + 1;
      end
    end else begin
      ack_q   <= 1'b0;
      slv_cnt <= 0;
    end
  end

  // ---------------- Bus monitor (samples on falling edge) ------------------
  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
  } xact_t;

  xact_t       obs_q[$];
  int          stb_pulses = 0;
  int          stb_cycles = 0;
  logic        pend = 1'b0;
  logic        stb_prev = 1'b0;
  logic [31:0] pend_adr, pend_dat;
  logic        pend_we;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend     = 1'b0;
      stb_prev = 1'b0;
    end else begin
      check("cyc_eq_stb", 64'(wb_cyc_o), 64'(wb_stb_o));
      if (pend) begin
        check("stb_held", 64'(wb_stb_o), 64'(1));
        check("adr_held", 64'(wb_adr_o), 64'(pend_adr));
        check("dat_held", 64'(wb_dat_o), 64'(pend_dat));
        check("we_held",  64'(wb_we_o),  64'(pend_we));
      end
      if (wb_stb_o) begin
        check("sel_ones", 64'(wb_sel_o), 64'(4'hF));
        stb_cycles++;
        if (!stb_prev) stb_pulses++;
        if (wb_ack_i) obs_q.push_back('{adr: wb_adr_o, we: wb_we_o, dat: wb_dat_o});
      end
      pend     = wb_stb_o && !wb_ack_i;
      pend_adr = wb_adr_o;
      pend_dat = wb_dat_o;
      pend_we  = wb_we_o;
      stb_prev = wb_stb_o;
    end
  end

  // ---------------- Reference memory model ---------------------------------
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // ---------------- Drivers -------------------------------------------------
  task automatic issue_cmd(input logic [31:0] a, input int n, input logic we);
    logic acc;
    bit   done = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_count = CW'(n);
    cmd_we    = we;
    for (int g = 0; g < 50 && !done; g++) begin
      acc = cmd_ready;
      @(negedge clk);
      done = acc;
    end
    if (!done) check("cmd_accept_timeout", 64'(0), 64'(1));
    cmd_valid = 1'b0;
  endtask

  // One command end to end; base==0 selects random write data.
  task automatic run_cmd(input logic [31:0] a, input int n, input logic we,
                         input int wait_st, input logic [31:0] base, input int stall_word);
    logic [31:0] exp_adr[$];
    logic [31:0] exp_dat[$];
    logic [31:0] d, adr;
    logic        acc, v, r;
    int          got, guard;
    bit          done;

    slv_wait = wait_st;
    obs_q.delete();
    stb_pulses = 0;
    stb_cycles = 0;
    for (int i = 0; i < n; i++) begin
      adr = a + 32'(i * SW);
      exp_adr.push_back(adr);
      if (we) begin
        d = (base == 0) ? $urandom : base + 32'(i);
        ref_mem[adr] = d;
      end else begin
        d = ref_read(adr);
      end
      exp_dat.push_back(d);
    end

    issue_cmd(a, n, we);

    if (n == 0) begin
      for (int k = 0; k < 4; k++) begin
        check("zero_stb",       64'(wb_stb_o),  64'(0));
        check("zero_busy",      64'(busy),      64'(0));
        check("zero_cmd_ready", 64'(cmd_ready), 64'(1));
        @(negedge clk);
      end
      check("zero_pulses", 64'(stb_pulses), 64'(0));
      return;
    end

    check("busy_after_accept", 64'(busy), 64'(1));

    if (we) begin
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = exp_dat[i];
        done = 0;
        for (int g = 0; g < 200 && !done; g++) begin
          acc = wr_ready;
          @(negedge clk);
          done = acc;
        end
        if (!done) check("wr_accept_timeout", 64'(0), 64'(1));
        wr_valid = 1'b0;
      end
    end else begin
      got   = 0;
      guard = 0;
      while (got < n && guard < 2000) begin
        guard++;
        if (got == stall_word && rd_valid) begin
          rd_ready = 1'b0;
          for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_rd_valid", 64'(rd_valid), 64'(1));
            check("stall_rd_data",  64'(rd_data),  64'(exp_dat[got]));
            check("stall_no_stb",   64'(wb_stb_o), 64'(0));
          end
          rd_ready = 1'b1;
        end else begin
          rd_ready = 1'($urandom_range(0, 1));
        end
        v = rd_valid;
        r = rd_ready;
        d = rd_data;
        @(negedge clk);
        if (v && r) begin
          check("rd_data", 64'(d), 64'(exp_dat[got]));
          got++;
        end
      end
      rd_ready = 1'b0;
      check("rd_word_count", 64'(got), 64'(n));
    end

    done = 0;
    for (int g = 0; g < 100 && !done; g++) begin
      if (!busy) done = 1;
      else @(negedge clk);
    end
    check("busy_drop",       64'(busy),      64'(0));
    check("cmd_ready_after", 64'(cmd_ready), 64'(1));
    check("xact_count",      64'(obs_q.size()), 64'(n));
    for (int i = 0; i < n && i < obs_q.size(); i++) begin
      check("xact_adr", 64'(obs_q[i].adr), 64'(exp_adr[i]));
      check("xact_we",  64'(obs_q[i].we),  64'(we));
      if (we) check("xact_dat", 64'(obs_q[i].dat), 64'(exp_dat[i]));
    end
    check("stb_pulses", 64'(stb_pulses), 64'(n));
    check("stb_cycles", 64'(stb_cycles), 64'(n * (wait_st + 2)));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_stb"},      64'(wb_stb_o),  64'(0));
    check({tag, "_cyc"},      64'(wb_cyc_o),  64'(0));
    check({tag, "_busy"},     64'(busy),      64'(0));
    check({tag, "_rd_valid"}, 64'(rd_valid),  64'(0));
    check({tag, "_wr_ready"}, 64'(wr_ready),  64'(0));
    check({tag, "_cmd_rdy"},  64'(cmd_ready), 64'(0));
  endtask

  // ---------------- Main sequence -----------------------------------------
  initial begin
    logic [31:0] ra;
    bit          seen;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_adr",  64'(wb_adr_o), 64'(0));
    check("reset_dat",  64'(wb_dat_o), 64'(0));
    check("reset_rdat", 64'(rd_data),  64'(0));
    check("reset_we",   64'(wb_we_o),  64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("cmd_ready_post_reset", 64'(cmd_ready), 64'(1));

    // Three-word write then read-back with a five-cycle stall on word 2.
    run_cmd(32'h100, 3, 1'b1, 0, 32'hA, -1);
    check("ram_0x100", 64'(slv_mem[32'h100]), 64'(32'hA));
    check("ram_0x104", 64'(slv_mem[32'h104]), 64'(32'hB));
    check("ram_0x108", 64'(slv_mem[32'h108]), 64'(32'hC));
    run_cmd(32'h100, 3, 1'b0, 0, 32'h0, 1);

    // Zero-length command.
    run_cmd(32'h180, 0, 1'b1, 0, 32'h0, -1);

    // Slow slave: four wait states on a single word each way.
    run_cmd(32'h200, 1, 1'b1, 4, 32'h0, -1);
    run_cmd(32'h200, 1, 1'b0, 4, 32'h0, -1);

    // Address wrap at the top of the space.
    run_cmd(32'hFFFF_FFFC, 2, 1'b1, 1, 32'h0, -1);
    run_cmd(32'hFFFF_FFFC, 2, 1'b0, 0, 32'h0, -1);
    check("ram_wrap_0", 64'(slv_mem[32'h0]), 64'(ref_mem[32'h0]));

    // Randomised commands over a small window so reads hit earlier writes.
    for (int t = 0; t < 12; t++) begin
      ra = 32'h400 + 32'($urandom_range(0, 15) * SW);
      run_cmd(ra, $urandom_range(1, 5), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), 32'h0, ($urandom_range(0, 1) == 1) ? 0 : -1);
    end

    // Reset while a read cycle is outstanding on the bus.
    slv_wait = 10;
    issue_cmd(32'h600, 4, 1'b0);
    seen = 0;
    for (int g = 0; g < 20 && !seen; g++) begin
      if (wb_stb_o) seen = 1;
      else @(negedge clk);
    end
    check("stb_before_reset", 64'(seen), 64'(1));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("cmd_ready_rerelease", 64'(cmd_ready), 64'(1));
    check("stb_after_release",   64'(wb_stb_o),  64'(0));
    run_cmd(32'h700, 2, 1'b1, 0, 32'h0, -1);
    run_cmd(32'h700, 2, 1'b0, 2, 32'h0, -1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always ends on its own.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_wb_stream_master

// File: doc/wb_stream_master.md
WB_STREAM_MASTER -- requirements
Module: wb_stream_master

Interface
REQ-001 DATA_WIDTH, 32, data bus width in bits (8/16/32/64).
REQ-002 ADDR_WIDTH, 32, byte address width.
REQ-003 SELECT_WIDTH, 4, byte-lane select width (DATA_WIDTH/8).
REQ-004 COUNT_WIDTH, 16, width of transfer word count.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 cmd_valid  in  1  command present.
REQ-008 cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
REQ-009 cmd_addr  in  ADDR_WIDTH  start byte address, word-aligned.
REQ-010 cmd_count  in  COUNT_WIDTH  number of words to transfer.
REQ-011 cmd_we  in  1  1 = write burst, 0 = read burst.
REQ-012 wr_data  in  DATA_WIDTH  write stream data.
REQ-013 wr_valid  in  1  write stream valid.
REQ-014 wr_ready  out  1  write stream ready.
REQ-015 rd_data  out  DATA_WIDTH  read stream data.
REQ-016 rd_valid  out  1  read stream valid.
REQ-017 rd_ready  in  1  read stream ready.
REQ-018 busy  out  1  high from command accept until last word completes.
REQ-019 wb_adr_o  out  ADDR_WIDTH  Wishbone ADR_O.
REQ-020 wb_dat_i  in  DATA_WIDTH  Wishbone DAT_I.
REQ-021 wb_dat_o  out  DATA_WIDTH  Wishbone DAT_O.
REQ-022 wb_we_o  out  1  Wishbone WE_O.
REQ-023 wb_sel_o  out  SELECT_WIDTH  Wishbone SEL_O; always all ones during a cycle.
REQ-024 wb_stb_o  out  1  Wishbone STB_O.
REQ-025 wb_ack_i  in  1  Wishbone ACK_I.
REQ-026 wb_cyc_o  out  1  Wishbone CYC_O; equals wb_stb_o.

Function
REQ-027 FSM states IDLE, WAIT_WR, BUS, HOLD_RD; all outputs registered.
REQ-028 IDLE: cmd_ready=1; on accept, latch addr/count/we, busy=1; count 0 -> stay IDLE, busy never asserts.
REQ-029 IDLE -> WAIT_WR (write) or BUS (read) on accept with nonzero count.
REQ-030 WAIT_WR: wr_ready=1; on wr_valid, capture wr_data into wb_dat_o, go BUS; wr_ready=0 in all other states.
REQ-031 BUS: wb_stb_o=wb_cyc_o=1, wb_adr_o=current address, wb_we_o=latched we; held unchanged until wb_ack_i sampled high.
REQ-032 Ack cycle: stb/cyc drop next cycle; address += SELECT_WIDTH (modulo 2^ADDR_WIDTH, wraps silently); count -= 1.
REQ-033 Read ack: capture wb_dat_i into rd_data, go HOLD_RD with rd_valid=1.
REQ-034 HOLD_RD: rd_valid and rd_data held until rd_ready; then rd_valid=0 next cycle.
REQ-035 After write ack or read handoff: count 0 -> IDLE, busy=0; else WAIT_WR (write) or BUS (read).
REQ-036 Minimum per-word latency against zero-wait slave: write 3 cycles (data accept, stb, ack); read 3 cycles to rd_valid.
REQ-037 wb_ack_i outside BUS ignored; cmd_valid outside IDLE ignored (cmd_ready=0).

Reset
REQ-038 rst_n low asynchronously forces IDLE, clears stb/cyc/we/busy/rd_valid/wr_ready, zeroes address, count, rd_data, wb_dat_o; cmd_ready=0 during reset, 1 first cycle after release.
REQ-039 Reset mid-burst abandons transfer; no Wishbone cycle outstanding after reset.

Structure
REQ-040 Package holds FSM state encoding and address-increment constant (SELECT_WIDTH bytes); no sub-module, single flat FSM.

Verification
REQ-041 Write addr 0x100, count 3, data 0xA,0xB,0xC into wb_ram-style slave -> words at 0x100/0x104/0x108; three stb pulses; busy drops after third ack.
REQ-042 Read back same, rd_ready held low 5 cycles on word 2 -> rd_data 0xB stable, rd_valid high throughout, no new stb until handoff.
REQ-043 count 0 command -> no stb, busy stays 0, cmd_ready stays 1.
REQ-044 Slave ack delayed 4 cycles -> stb/adr/dat stable for 4 cycles, single word transferred.
REQ-045 Start addr 0xFFFFFFFC, count 2 -> second access at 0x00000000.
REQ-046 rst_n low during BUS -> stb/cyc/busy 0 immediately (asynchronously); next command executes normally.
